// File: rtl/or_gate_pkg.sv
// ---------------------------------------------------------------------------
// or_gate_pkg
// Shared definitions for the or_gate_core slice: default operand width,
// default activity-counter width and the default counter type.
// ---------------------------------------------------------------------------
package or_gate_pkg;

  localparam int OR_WIDTH_DEFAULT = 1;
  localparam int OR_CNT_W_DEFAULT = 16;

  typedef logic [OR_CNT_W_DEFAULT-1:0] or_cnt_t;

endpackage : or_gate_pkg

// File: rtl/or_gate_sat_counter.sv
// ---------------------------------------------------------------------------
// or_gate_sat_counter
// Saturating up-counter. Advances by one on each rising edge where inc is
// high and sticks at all-ones instead of wrapping.
//
// Ports:
//   clk  - system clock, rising-edge active
//   rst  - synchronous, active-high reset (clears cnt)
//   inc  - count enable for this edge
//   cnt  - current count, CNT_W bits
// ---------------------------------------------------------------------------
module or_gate_sat_counter
  import or_gate_pkg::*;
#(
  parameter int CNT_W = OR_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // NOTE: reset is sampled on the clock edge, so it lives inside the
  // always_ff body rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule : or_gate_sat_counter

// File: rtl/or_gate_core.sv
// ---------------------------------------------------------------------------
// or_gate_core
// Bit-wise two-input OR with a combinational output, a registered copy,
// a registered reduction-OR, a sticky "ever high" flag and an optional
// saturating count of cycles where any result bit was high.
//
// Build option: define OR_GATE_STATS_EN to add the hi_cnt port and counter.
//
// Ports:
//   clk    - system clock, rising-edge active
//   rst    - synchronous, active-high reset
//   a, b   - operands, WIDTH bits
//   y      - a | b, combinational, independent of clk/rst
//   y_q    - y registered
//   any_q  - |y registered
//   sticky - set on the first edge with |y = 1, held until rst
//   hi_cnt - saturating count of edges with |y = 1 (OR_GATE_STATS_EN only)
// ---------------------------------------------------------------------------
module or_gate_core
  import or_gate_pkg::*;
#(
  parameter int WIDTH = OR_WIDTH_DEFAULT,
  parameter int CNT_W = OR_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             any_q,
  output logic             sticky
`ifdef OR_GATE_STATS_EN
  ,
  output logic [CNT_W-1:0] hi_cnt
`endif
);

  logic y_any;

  // Gate-level path: no clock or reset involvement, valid with clk stopped.
  assign y     = a | b;
  assign y_any = |y;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q    <= '0;
      any_q  <= 1'b0;
      sticky <= 1'b0;
    end else begin
      y_q   <= y;
      any_q <= y_any;
      if (y_any) begin
        sticky <= 1'b1;
      end
    end
  end

`ifdef OR_GATE_STATS_EN
  or_gate_sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .clk (clk),
    .rst (rst),
    .inc (y_any),
    .cnt (hi_cnt)
  );
`else
  // Statistics build disabled: CNT_W only sizes hi_cnt, so it is unused here.
`endif

endmodule : or_gate_core

// File: tb/tb_or_gate_core.sv
// ---------------------------------------------------------------------------
// tb_or_gate_core
// Self-checking bench for or_gate_core. A WIDTH=1 instance covers the
// combinational truth table with the clock stopped; a WIDTH=8, CNT_W=4
// instance covers the registered outputs through a scoreboard queue fed by
// a small reference model. hi_cnt checks exist only with OR_GATE_STATS_EN.
// ---------------------------------------------------------------------------
module tb_or_gate_core;

  localparam int W8     = 8;
  localparam int CW8    = 4;
  localparam int CW1    = 16;
  localparam int CNTMAX = (1 << CW8) - 1;

  typedef struct {
    logic [W8-1:0] y_q;
    logic          any_q;
    logic          sticky;
    int            cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          clk_run = 1'b0;
  logic          rst = 1'b0;

  logic [0:0]    a1 = '0, b1 = '0;
  logic [0:0]    y1, y_q1;
  logic          any_q1, sticky1;

  logic [W8-1:0] a8 = '0, b8 = '0;
  logic [W8-1:0] y8, y_q8;
  logic          any_q8, sticky8;

`ifdef OR_GATE_STATS_EN
  logic [CW1-1:0] hi_cnt1;
  logic [CW8-1:0] hi_cnt8;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  // Model state for the registered outputs.
  logic m_sticky = 1'b0;
  int   m_cnt    = 0;

  always #5 if (clk_run) clk = ~clk;

  or_gate_core #(
    .WIDTH (1),
    .CNT_W (CW1)
  ) dut_w1 (
    .clk    (clk),
    .rst    (rst),
    .a      (a1),
    .b      (b1),
    .y      (y1),
    .y_q    (y_q1),
    .any_q  (any_q1),
    .sticky (sticky1)
`ifdef OR_GATE_STATS_EN
    ,
    .hi_cnt (hi_cnt1)
`endif
  );

  or_gate_core #(
    .WIDTH (W8),
    .CNT_W (CW8)
  ) dut_w8 (
    .clk    (clk),
    .rst    (rst),
    .a      (a8),
    .b      (b8),
    .y      (y8),
    .y_q    (y_q8),
    .any_q  (any_q8),
    .sticky (sticky8)
`ifdef OR_GATE_STATS_EN
    ,
    .hi_cnt (hi_cnt8)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, check y immediately, push the registered
  // expectation for the coming edge, then wait for that edge.
  task automatic step(input logic [W8-1:0] na, input logic [W8-1:0] nb,
                      input logic nrst);
    exp_t e;
    logic [W8-1:0] ey;
    a8  = na;
    b8  = nb;
    rst = nrst;
    ey  = 8'h00;
    for (int i = 0; i < W8; i++) ey[i] = na[i] | nb[i];
    #1 check("y8", 32'(y8), 32'(ey));
    if (nrst) begin
      m_sticky = 1'b0;
      m_cnt    = 0;
      e.y_q    = '0;
      e.any_q  = 1'b0;
    end else begin
      e.y_q   = ey;
      e.any_q = (ey != 8'h00);
      if (ey != 8'h00) begin
        m_sticky = 1'b1;
        if (m_cnt < CNTMAX) m_cnt++;
      end
    end
    e.sticky = m_sticky;
    e.cnt    = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Compare registered outputs one time unit after each edge they cover.
  always @(posedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      #1;
      check("y_q", 32'(y_q8), 32'(e.y_q));
      check("any_q", 32'(any_q8), 32'(e.any_q));
      check("sticky", 32'(sticky8), 32'(e.sticky));
`ifdef OR_GATE_STATS_EN
      check("hi_cnt", 32'(hi_cnt8), 32'(e.cnt));
`endif
    end
  end

  initial begin
    logic [1:0] pat;
    logic       ey1;

    // Clock stopped: truth table on the 1-bit instance.
    for (int i = 0; i < 4; i++) begin
      pat = 2'(i);
      a1  = pat[1];
      b1  = pat[0];
      ey1 = (i != 0);
      #10 check("y1_truth", 32'(y1), 32'(ey1));
    end

    // Clock stopped: 8-bit combinational result.
    a8 = 8'hA5;
    b8 = 8'h0F;
    #1 check("y8_idle", 32'(y8), 32'hAF);

    clk_run = 1'b1;

    // Reset with inputs high: y follows inputs, registers clear.
    step(8'h01, 8'h01, 1'b1);
    // First edge after reset captures.
    step(8'h01, 8'h01, 1'b0);
    step(8'hA5, 8'h0F, 1'b0);

    // Quiet period then three active edges.
    step(8'h00, 8'h00, 1'b1);
    repeat (5) step(8'h00, 8'h00, 1'b0);
    repeat (3) step(8'h01, 8'h00, 1'b0);
    repeat (2) step(8'h00, 8'h00, 1'b0);

    // Mid-operation reset with |y = 1 wins over capture.
    step(8'h80, 8'h01, 1'b1);

    // Saturation: 20 active edges on a 4-bit counter.
    repeat (20) step(8'h01, 8'h00, 1'b0);
    step(8'h00, 8'h00, 1'b0);

    // Let the scoreboard drain, bounded.
    repeat (3) @(posedge clk);
    #2 check("sb_drain", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_or_gate_core

// File: doc/or_gate_core.md
# or_gate_core

Bit-wise two-input OR primitive with a combinational output plus a registered copy and an optional saturating activity counter. Sits at the leaf level of combinational datapaths. The unregistered output serves gate-level use. The registered and statistics outputs let parent blocks sample the result synchronously on the system clock.

## Interface

Parameters:
- WIDTH, 1, bit width of operands and results
- CNT_W, 16, width of the activity counter

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous, active-high reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- y  output  WIDTH  combinational result, a | b
- y_q  output  WIDTH  registered a | b
- any_q  output  1  registered reduction-OR of y
- sticky  output  1  set once any bit of y has been 1 since reset
- hi_cnt  output  CNT_W  count of cycles with any bit of y high; only present with OR_GATE_STATS_EN

## Operation

- y = a | b, bit-wise, purely combinational.
  - No dependency on clk or rst.
  - Valid with the clock stopped.
- y_q captures y each rising clk edge; any_q captures |y.
- sticky sets on a clock edge where |y = 1, then holds until rst.
- hi_cnt (stats enabled):
  - Increments by 1 on each edge where |y = 1.
  - Saturates at 2^CNT_W−1; no wrap.
- X/Z on inputs: no special handling. Output follows standard OR semantics, so 1 | x = 1.
- Truth table per bit:
  - 0,0 → 0
  - 0,1 → 1
  - 1,0 → 1
  - 1,1 → 1

## Timing

- y: zero-cycle latency, combinational path only.
- y_q, any_q, sticky, hi_cnt: one-cycle latency from input change to the next rising edge.
- Reset values, when rst is high at a rising edge:
  - y_q = 0, any_q = 0, sticky = 0, hi_cnt = 0.
  - y is unaffected by reset.
- rst has priority over capture:
  - With rst = 1 and |y = 1 on the same edge, sticky and hi_cnt are still cleared.
  - They update from the following edge.
- Reset mid-operation: registered outputs clear on that edge. Counting resumes normally afterwards.
- Saturation boundary: at hi_cnt = max with |y = 1, the value holds at max.

## Configuration

- OR_GATE_STATS_EN defined:
  - hi_cnt port and counter logic are present.
  - The counter is implemented with a saturating sub-module.
- OR_GATE_STATS_EN undefined:
  - hi_cnt port and counter are removed.
  - All other ports and behaviour are identical.

## Structure

- Shared package or_gate_pkg:
  - OR_WIDTH_DEFAULT = 1, OR_CNT_W_DEFAULT = 16.
  - Typedef or_cnt_t for the counter type.
- One sub-module, or_gate_sat_counter.
  - Ports: clk, rst, inc, cnt.
  - Behaviour: saturating up-counter, instantiated only under OR_GATE_STATS_EN.
- The OR and registers sit in the top module.

## Test plan

- WIDTH=1, clock idle, drive a/b = 00, 01, 10, 11 with 10 ns between steps → y = 0, 1, 1, 1 after each step.
- WIDTH=8, a=0xA5, b=0x0F → y=0xAF immediately; y_q=0xAF and any_q=1 after one rising edge.
- Assert rst for one edge with a=b=1 → y=1 while y_q, any_q, sticky and hi_cnt read 0; one edge after rst drops, y_q=1, sticky=1, hi_cnt=1.
- After reset, hold a=b=0 for 5 edges, then set a=1 for 3 edges → sticky rises on the first high edge, stays 1 after inputs return to 0; hi_cnt=3.
- Stats enabled, CNT_W=4, hold a=1 for 20 edges → hi_cnt reaches 15 and holds at 15.
- Build without OR_GATE_STATS_EN → no hi_cnt port; previous y/y_q/sticky scenarios give identical results.
